// File: rtl/feature_match_pkg.sv
// Shared definitions for the feature-matching pipeline (distance engine and
// best-match tracker).
package feature_match_pkg;

    localparam int unsigned DIST_W = 23;
    localparam logic [DIST_W-1:0] DIST_MAX = 23'h7FFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DECIDE,
        DONE
    } fm_state_e;

endpackage

// File: rtl/dist_min2_tracker.sv
// Running tracker of the smallest and second-smallest distance seen since the
// last clear, plus the arrival index of the smallest.
module dist_min2_tracker #(
    parameter int unsigned DIST_W = 23,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_upd,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DIST_W-1:0] i_dist,
    output logic [DIST_W-1:0] o_best,
    output logic [DIST_W-1:0] o_second,
    output logic [IDX_W-1:0]  o_best_idx
);

    logic [DIST_W-1:0] r_best;
    logic [DIST_W-1:0] r_second;
    logic [IDX_W-1:0]  r_best_idx;

    // Clear wins over update, so a sample coinciding with a restart is dropped;
    // strict compares keep the earlier index on ties and push equals to second.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_best     <= '1;
            r_second   <= '1;
            r_best_idx <= '0;
        end else if (i_clear) begin
            r_best     <= '1;
            r_second   <= '1;
            r_best_idx <= '0;
        end else if (i_upd) begin
            if (i_dist < r_best) begin
                r_second   <= r_best;
                r_best     <= i_dist;
                r_best_idx <= i_idx;
            end else if (i_dist < r_second) begin
                r_second <= i_dist;
            end
        end
    end

    assign o_best     = r_best;
    assign o_second   = r_second;
    assign o_best_idx = r_best_idx;

endmodule

// File: rtl/descriptor_best_match.sv
// Best / second-best distance search over one query, followed by an absolute
// threshold and a ratio test; the result is offered under a valid/ack handshake.
module descriptor_best_match
    import feature_match_pkg::fm_state_e;
#(
    parameter int unsigned        DIST_W    = 23,
    parameter int unsigned        IDX_W     = 10,
    parameter int unsigned        RATIO_NUM = 16,
    parameter int unsigned        RATIO_DEN = 25,
    parameter logic [DIST_W-1:0]  MAX_DIST  = 23'h0FFFFF
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [IDX_W-1:0]  iNumDb,
    input  logic [DIST_W-1:0] iDist,
    input  logic              iDist_Valid,
    input  logic              iMatch_Ack,
    output logic              oBusy,
    output logic              oMatch_Valid,
    output logic              oMatch_Found,
    output logic [IDX_W-1:0]  oBest_Idx,
    output logic [DIST_W-1:0] oBest_Dist,
    output logic [DIST_W-1:0] oSecond_Dist,
    output logic              oOverrun
);

    localparam int unsigned PROD_W = DIST_W + 5;

    fm_state_e         r_state;
    logic [IDX_W-1:0]  r_num;
    logic [IDX_W-1:0]  r_count;
    logic              r_busy;
    logic              r_match_valid;
    logic              r_found;
    logic [IDX_W-1:0]  r_best_idx;
    logic [DIST_W-1:0] r_best_dist;
    logic [DIST_W-1:0] r_second_dist;
    logic              r_overrun;

    logic              w_start;
    logic              w_upd;
    logic [IDX_W-1:0]  w_count_inc;
    logic [DIST_W-1:0] w_best;
    logic [DIST_W-1:0] w_second;
    logic [IDX_W-1:0]  w_best_idx;
    logic [PROD_W-1:0] w_best_scaled;
    logic [PROD_W-1:0] w_second_scaled;
    logic              w_found;

    // Start is honoured in IDLE, as a restart in SEARCH, and in DONE only with ack.
    always_comb begin
        w_start = 1'b0;
        w_upd   = 1'b0;
        case (r_state)
            feature_match_pkg::IDLE:   w_start = iStart;
            feature_match_pkg::SEARCH: begin
                w_start = iStart;
                w_upd   = iDist_Valid && !iStart;
            end
            feature_match_pkg::DONE:   w_start = iStart && iMatch_Ack;
            default:                   w_start = 1'b0;
        endcase
    end

    assign w_count_inc = r_count + 1'b1;

    dist_min2_tracker #(
        .DIST_W (DIST_W),
        .IDX_W  (IDX_W)
    ) u_tracker (
        .i_clk      (iClk),
        .i_rst_n    (iRst_n),
        .i_clear    (w_start),
        .i_upd      (w_upd),
        .i_idx      (r_count),
        .i_dist     (iDist),
        .o_best     (w_best),
        .o_second   (w_second),
        .o_best_idx (w_best_idx)
    );

    // Full-width products so the ratio compare never truncates.
    assign w_best_scaled   = PROD_W'(w_best)   * PROD_W'(RATIO_DEN);
    assign w_second_scaled = PROD_W'(w_second) * PROD_W'(RATIO_NUM);
    assign w_found         = (w_best <= MAX_DIST) && (w_best_scaled < w_second_scaled);

    // Search control FSM with registered result, handshake and overrun flag.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state       <= feature_match_pkg::IDLE;
            r_num         <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_match_valid <= 1'b0;
            r_found       <= 1'b0;
            r_best_idx    <= '0;
            r_best_dist   <= '0;
            r_second_dist <= '0;
            r_overrun     <= 1'b0;
        end else if (w_start) begin
            r_num         <= iNumDb;
            r_count       <= '0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b1;
            r_match_valid <= 1'b0;
            r_state       <= (iNumDb == '0) ? feature_match_pkg::DECIDE
                                            : feature_match_pkg::SEARCH;
        end else begin
            case (r_state)
                feature_match_pkg::IDLE: begin
                    if (iDist_Valid) r_overrun <= 1'b1;
                end
                feature_match_pkg::SEARCH: begin
                    if (iDist_Valid) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_num) r_state <= feature_match_pkg::DECIDE;
                    end
                end
                feature_match_pkg::DECIDE: begin
                    r_found       <= w_found;
                    r_best_idx    <= w_best_idx;
                    r_best_dist   <= w_best;
                    r_second_dist <= w_second;
                    r_match_valid <= 1'b1;
                    r_state       <= feature_match_pkg::DONE;
                    if (iDist_Valid) r_overrun <= 1'b1;
                end
                feature_match_pkg::DONE: begin
                    if (iMatch_Ack) begin
                        r_match_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= feature_match_pkg::IDLE;
                    end
                    if (iDist_Valid) r_overrun <= 1'b1;
                end
                default: r_state <= feature_match_pkg::IDLE;
            endcase
        end
    end

    assign oBusy        = r_busy;
    assign oMatch_Valid = r_match_valid;
    assign oMatch_Found = r_found;
    assign oBest_Idx    = r_best_idx;
    assign oBest_Dist   = r_best_dist;
    assign oSecond_Dist = r_second_dist;
    assign oOverrun     = r_overrun;

endmodule
